vector_ping_pong_ctrl: RTL
==========================

// Module: vector_ping_pong_ctrl
// PURPOSE
// - Sequencer for the ping-pong vector RAM load wrapper.
// - Runs a load phase: asserts cfg_en and counts cfg write beats until one full vector (LENGTH/PARALLELISM beats) is in the x RAM.
// - Then runs n_iters compute iterations. Each one is a one-cycle iter_start, a wait for iter_done from the compute engine, and a ping toggle.
// - Sits between the top-level command/CSR logic and the wrapper's ping/cfg_en inputs.
// PARAMETERS
// - LENGTH       1024  vector length in elements
// - PARALLELISM  4     elements per beat; LENGTH % PARALLELISM == 0
// - ITER_WIDTH   16    width of iteration count and counter
// - Derived: BEATS = LENGTH/PARALLELISM; BEAT_W = $clog2(BEATS)+1
// PORTS
// - clk         in   1           clock, all state on rising edge
// - rst_n       in   1           asynchronous active-low reset
// - start       in   1           start request; sampled only in IDLE
// - n_iters     in   ITER_WIDTH  iteration count, latched on accepted start
// - abort       in   1           cancel; returns to IDLE from any state
// - load_beat   in   1           one cfg write beat accepted by the target RAM this cycle
// - iter_done   in   1           compute engine finished the current iteration (pulse)
// - ping        out  1           ping select to the wrapper
// - cfg_en      out  1           cfg port owns one RAM (high only in LOAD)
// - load_ready  out  1           loader may issue beats (== cfg_en)
// - iter_start  out  1           one-cycle pulse: begin one iteration
// - iter_count  out  ITER_WIDTH  completed iterations in the current run
// - busy        out  1           state != IDLE
// - done        out  1           one-cycle pulse: run complete
// BEHAVIOUR
// - Reset values: state=IDLE; ping=0, cfg_en=0, iter_start=0, done=0, busy=0; iter_count=0, beat_cnt=0, n_lat=0.
// - All outputs are registered or decoded from registered state only; no input-to-output combinational paths.
// - States: IDLE, LOAD, ISSUE, RUN, DONE.
// - IDLE:
//   - start=1 -> LOAD next cycle.
//   - Latch n_iters into n_lat; clear iter_count and beat_cnt; set ping=1, so cfg is routed to the x RAM.
// - LOAD:
//   - cfg_en=load_ready=1.
//   - Each load_beat increments beat_cnt.
//   - load_beat while beat_cnt==BEATS-1: the next state is ISSUE if n_lat!=0, else DONE. On that edge ping<=0 and cfg_en falls.
//   - Extra beats are impossible because cfg_en drops on the same edge.
// - ISSUE:
//   - iter_start=1 for exactly this cycle -> RUN.
// - RUN:
//   - Wait for iter_done. iter_done outside RUN is ignored; there is no queuing.
//   - On iter_done: ping<=~ping and iter_count<=iter_count+1.
//   - Next state is DONE if iter_count+1==n_lat, else ISSUE.
// - DONE:
//   - done=1 for one cycle -> IDLE.
//   - ping and iter_count hold until the next start; final ping identifies the RAM holding the result.
// - Latency:
//   - start at edge t -> cfg_en=1 at t+1.
//   - Last load_beat at t -> iter_start=1 at t+1.
//   - iter_done at t -> toggled ping and next iter_start both at t+1, so there is one idle cycle between iterations.
// - Simultaneous events:
//   - abort has priority over every other input in every state.
//   - Abort: next state IDLE, cfg_en=0, no done pulse; ping/iter_count retain their values.
//   - start is ignored while busy. start together with abort in IDLE is ignored.
// - Width rules:
//   - iter_count wraps modulo 2^ITER_WIDTH. n_lat=2^ITER_WIDTH-1 is legal.
//   - The compare iter_count+1==n_lat uses ITER_WIDTH+1 bits.
// - Reset mid-operation: immediate return to reset values, no done pulse.
// STRUCTURE
// - vector_ram_pkg gains typedef enum logic [2:0] pp_ctrl_state_e {PPC_IDLE, PPC_LOAD, PPC_ISSUE, PPC_RUN, PPC_DONE}.
// - Same package gains function beats_f(LENGTH, PARALLELISM).
// - Single module: one always_ff for state/counters/ping, one always_comb for next-state. No sub-module.
// - Elaboration-time $error if LENGTH % PARALLELISM != 0.
// TESTING (LENGTH=16, PARALLELISM=4 -> BEATS=4, ITER_WIDTH=8)
// 1. Reset held, then released -> all outputs 0, busy=0. start while rst_n=0 has no effect.
// 2. start, n_iters=3; 4 load_beats back-to-back; iter_done 5 cycles after each iter_start:
//    - cfg_en high exactly 4 cycles.
//    - Three iter_start pulses; ping sequence 1,0,1,0,1.
//    - iter_count 0->3; one done pulse; final ping=1.
// 3. Gapped load beats (beat, 3 idle, beat, ...):
//    - cfg_en stays high until the 4th beat.
//    - iter_start exactly 1 cycle after the 4th beat.
//    - iter_done pulses during LOAD/ISSUE are ignored.
// 4. n_iters=0 -> load of 4 beats, then done 1 cycle later, no iter_start, ping=0.
// 5. Abort in LOAD after 2 beats, then abort in RUN of iteration 2:
//    - IDLE next cycle, no done, cfg_en=0, iter_count=1 retained.
//    - A following start re-runs cleanly from iter_count=0.
// 6. start pulsed during RUN, and start+abort together in IDLE -> both ignored; iter_done+abort together -> IDLE, no done.

Source files
------------

// File: rtl/vector_ram_pkg.sv
// Shared types and helpers for the ping-pong vector RAM slice.
// Holds the load/compute sequencer state encoding.
package vector_ram_pkg;

  typedef enum logic [2:0] {
    PPC_IDLE,
    PPC_LOAD,
    PPC_ISSUE,
    PPC_RUN,
    PPC_DONE
  } pp_ctrl_state_e;

  function automatic int beats_f(
    input int length,
    input int parallelism
  );
    return length / parallelism;
  endfunction

endpackage

// File: rtl/vector_ping_pong_ctrl.sv
// Load/compute sequencer for the ping-pong vector RAM wrapper.
// Loads one vector, then runs n_iters ping-toggling iterations.
module vector_ping_pong_ctrl
  import vector_ram_pkg::*;
#(
  parameter int LENGTH      = 1024,
  parameter int PARALLELISM = 4,
  parameter int ITER_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] n_iters,
  input  logic                  abort,
  input  logic                  load_beat,
  input  logic                  iter_done,
  output logic                  ping,
  output logic                  cfg_en,
  output logic                  load_ready,
  output logic                  iter_start,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic                  busy,
  output logic                  done
);

  localparam int BEATS  = beats_f(LENGTH, PARALLELISM);
  localparam int BEAT_W = $clog2(BEATS) + 1;

  if (LENGTH % PARALLELISM != 0) begin : g_len_chk
    $error("LENGTH must be a multiple of PARALLELISM");
  end

  pp_ctrl_state_e state, state_nx;

  logic [BEAT_W-1:0]     beat_cnt;
  logic [ITER_WIDTH-1:0] n_lat;
  logic                  last_beat;
  logic                  last_iter;

  assign last_beat = load_beat &&
    (beat_cnt == BEAT_W'(BEATS - 1));

  // Extra bit keeps n_lat = all-ones reachable
  assign last_iter =
    ({1'b0, iter_count} + (ITER_WIDTH+1)'(1))
    == {1'b0, n_lat};

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = PPC_IDLE;
    end else begin
      unique case (state)
        PPC_IDLE:
          if (start) state_nx = PPC_LOAD;
        PPC_LOAD:
          if (last_beat)
            state_nx = (n_lat != '0) ?
              PPC_ISSUE : PPC_DONE;
        PPC_ISSUE:
          state_nx = PPC_RUN;
        PPC_RUN:
          if (iter_done)
            state_nx = last_iter ?
              PPC_DONE : PPC_ISSUE;
        PPC_DONE:
          state_nx = PPC_IDLE;
        default:
          state_nx = PPC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PPC_IDLE;
      ping       <= 1'b0;
      iter_count <= '0;
      beat_cnt   <= '0;
      n_lat      <= '0;
    end else begin
      state <= state_nx;
      if (!abort) begin
        unique case (state)
          PPC_IDLE:
            if (start) begin
              n_lat      <= n_iters;
              iter_count <= '0;
              beat_cnt   <= '0;
              ping       <= 1'b1;
            end
          PPC_LOAD: begin
            if (load_beat)
              beat_cnt <= beat_cnt + 1'b1;
            if (last_beat)
              ping <= 1'b0;
          end
          PPC_RUN:
            if (iter_done) begin
              ping       <= ~ping;
              iter_count <= iter_count + 1'b1;
            end
          default: ;
        endcase
      end
    end
  end

  assign cfg_en     = (state == PPC_LOAD);
  assign load_ready = cfg_en;
  assign iter_start = (state == PPC_ISSUE);
  assign done       = (state == PPC_DONE);
  assign busy       = (state != PPC_IDLE);

endmodule
